// File: rtl/lsu_rd_arb.sv
// Round-robin read arbiter: two load requesters share one AXI-style read port,
// one burst outstanding at a time, with sticky response/ID/length error flags.
module lsu_rd_arb #(
    parameter logic [7:0] IRAM_ID = 8'h01,
    parameter logic [7:0] WRAM_ID = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld0_req_vld,
    input  logic [9:0]  ld0_req_addr,
    input  logic [7:0]  ld0_req_len,
    input  logic [2:0]  ld0_req_size,
    input  logic [2:0]  ld0_req_str,
    input  logic [7:0]  ld0_req_num,
    output logic        ld0_req_rdy,
    output logic        ld0_rvld,
    output logic [63:0] ld0_rdata,
    output logic        ld0_rlast,
    input  logic        ld0_rrdy,
    input  logic        ld1_req_vld,
    input  logic [9:0]  ld1_req_addr,
    input  logic [7:0]  ld1_req_len,
    input  logic [2:0]  ld1_req_size,
    input  logic [2:0]  ld1_req_str,
    input  logic [7:0]  ld1_req_num,
    output logic        ld1_req_rdy,
    output logic        ld1_rvld,
    output logic [63:0] ld1_rdata,
    output logic        ld1_rlast,
    input  logic        ld1_rrdy,
    output logic [7:0]  lsu_axi_arid,
    output logic [9:0]  lsu_axi_araddr,
    output logic [7:0]  lsu_axi_arlen,
    output logic [2:0]  lsu_axi_arsize,
    output logic [1:0]  lsu_axi_arburst,
    output logic [2:0]  lsu_axi_arstr,
    output logic [7:0]  lsu_axi_arnum,
    output logic        lsu_axi_arvld,
    input  logic        axi_lsu_arrdy,
    input  logic [7:0]  axi_lsu_rid,
    input  logic [63:0] axi_lsu_rdata,
    input  logic [1:0]  axi_lsu_rresp,
    input  logic        axi_lsu_rlast,
    input  logic        axi_lsu_rvld,
    output logic        lsu_axi_rrdy,
    output logic        arb_busy,
    output logic [2:0]  arb_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e      state_q;
    logic        owner_q;
    logic        prio_q;   // 1: ld1 wins a tie, 0: ld0 wins a tie
    logic [7:0]  id_q;
    logic [9:0]  addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [2:0]  str_q;
    logic [7:0]  num_q;
    logic [7:0]  cnt_q;
    logic [2:0]  err_q;

    logic        gnt0;
    logic        gnt1;
    logic        in_r;
    logic        beat;
    logic [2:0]  err_set;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            if (ld0_req_vld && ld1_req_vld) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = ld0_req_vld;
                gnt1 = ld1_req_vld;
            end
        end
    end

    assign ld0_req_rdy = gnt0;
    assign ld1_req_rdy = gnt1;

    assign in_r         = (state_q == StR);
    assign lsu_axi_rrdy = in_r & (owner_q ? ld1_rrdy : ld0_rrdy);
    assign beat         = in_r & axi_lsu_rvld & lsu_axi_rrdy;

    assign ld0_rvld  = in_r & ~owner_q & axi_lsu_rvld;
    assign ld1_rvld  = in_r & owner_q & axi_lsu_rvld;
    assign ld0_rlast = in_r & ~owner_q & axi_lsu_rlast;
    assign ld1_rlast = in_r & owner_q & axi_lsu_rlast;
    assign ld0_rdata = axi_lsu_rdata;
    assign ld1_rdata = axi_lsu_rdata;

    // Length check compares the pre-increment count: the last beat of arlen+1 beats sees arlen.
    assign err_set = {beat & axi_lsu_rlast & (cnt_q != len_q),
                      beat & (axi_lsu_rid != id_q),
                      beat & (axi_lsu_rresp != 2'b00)};

    assign lsu_axi_arid    = id_q;
    assign lsu_axi_araddr  = addr_q;
    assign lsu_axi_arlen   = len_q;
    assign lsu_axi_arsize  = size_q;
    assign lsu_axi_arburst = 2'b01;
    assign lsu_axi_arstr   = str_q;
    assign lsu_axi_arnum   = num_q;
    assign lsu_axi_arvld   = (state_q == StAr);
    assign arb_busy        = (state_q != StIdle);
    assign arb_err         = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            id_q    <= 8'h00;
            addr_q  <= 10'h000;
            len_q   <= 8'h00;
            size_q  <= 3'b000;
            str_q   <= 3'b000;
            num_q   <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 3'b000;
        end else begin
            err_q <= (err_clr ? 3'b000 : err_q) | err_set;
            unique case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        state_q <= StAr;
                        owner_q <= gnt1;
                        prio_q  <= gnt0;
                        id_q    <= gnt1 ? WRAM_ID : IRAM_ID;
                        addr_q  <= gnt1 ? ld1_req_addr : ld0_req_addr;
                        len_q   <= gnt1 ? ld1_req_len : ld0_req_len;
                        size_q  <= gnt1 ? ld1_req_size : ld0_req_size;
                        str_q   <= gnt1 ? ld1_req_str : ld0_req_str;
                        num_q   <= gnt1 ? ld1_req_num : ld0_req_num;
                    end
                end
                StAr: begin
                    if (axi_lsu_arrdy) begin
                        state_q <= StR;
                        cnt_q   <= 8'h00;
                    end
                end
                StR: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (axi_lsu_rlast) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rd_arb.sv
// Directed bench for lsu_rd_arb: inputs change 1 ns after posedge, outputs checked 4 ns later.
module tb_lsu_rd_arb;

    logic        clk;
    logic        rst_n;
    logic        ld0_req_vld, ld1_req_vld;
    logic [9:0]  ld0_req_addr, ld1_req_addr;
    logic [7:0]  ld0_req_len, ld1_req_len;
    logic [2:0]  ld0_req_size, ld1_req_size;
    logic [2:0]  ld0_req_str, ld1_req_str;
    logic [7:0]  ld0_req_num, ld1_req_num;
    logic        ld0_req_rdy, ld1_req_rdy;
    logic        ld0_rvld, ld1_rvld;
    logic [63:0] ld0_rdata, ld1_rdata;
    logic        ld0_rlast, ld1_rlast;
    logic        ld0_rrdy, ld1_rrdy;
    logic [7:0]  lsu_axi_arid;
    logic [9:0]  lsu_axi_araddr;
    logic [7:0]  lsu_axi_arlen;
    logic [2:0]  lsu_axi_arsize;
    logic [1:0]  lsu_axi_arburst;
    logic [2:0]  lsu_axi_arstr;
    logic [7:0]  lsu_axi_arnum;
    logic        lsu_axi_arvld;
    logic        axi_lsu_arrdy;
    logic [7:0]  axi_lsu_rid;
    logic [63:0] axi_lsu_rdata;
    logic [1:0]  axi_lsu_rresp;
    logic        axi_lsu_rlast;
    logic        axi_lsu_rvld;
    logic        lsu_axi_rrdy;
    logic        arb_busy;
    logic [2:0]  arb_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;
    int nbeats = 0;

    lsu_rd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ld0_req_vld(ld0_req_vld), .ld0_req_addr(ld0_req_addr), .ld0_req_len(ld0_req_len),
        .ld0_req_size(ld0_req_size), .ld0_req_str(ld0_req_str), .ld0_req_num(ld0_req_num),
        .ld0_req_rdy(ld0_req_rdy), .ld0_rvld(ld0_rvld), .ld0_rdata(ld0_rdata),
        .ld0_rlast(ld0_rlast), .ld0_rrdy(ld0_rrdy),
        .ld1_req_vld(ld1_req_vld), .ld1_req_addr(ld1_req_addr), .ld1_req_len(ld1_req_len),
        .ld1_req_size(ld1_req_size), .ld1_req_str(ld1_req_str), .ld1_req_num(ld1_req_num),
        .ld1_req_rdy(ld1_req_rdy), .ld1_rvld(ld1_rvld), .ld1_rdata(ld1_rdata),
        .ld1_rlast(ld1_rlast), .ld1_rrdy(ld1_rrdy),
        .lsu_axi_arid(lsu_axi_arid), .lsu_axi_araddr(lsu_axi_araddr),
        .lsu_axi_arlen(lsu_axi_arlen), .lsu_axi_arsize(lsu_axi_arsize),
        .lsu_axi_arburst(lsu_axi_arburst), .lsu_axi_arstr(lsu_axi_arstr),
        .lsu_axi_arnum(lsu_axi_arnum), .lsu_axi_arvld(lsu_axi_arvld),
        .axi_lsu_arrdy(axi_lsu_arrdy),
        .axi_lsu_rid(axi_lsu_rid), .axi_lsu_rdata(axi_lsu_rdata), .axi_lsu_rresp(axi_lsu_rresp),
        .axi_lsu_rlast(axi_lsu_rlast), .axi_lsu_rvld(axi_lsu_rvld),
        .lsu_axi_rrdy(lsu_axi_rrdy), .arb_busy(arb_busy), .arb_err(arb_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        ld0_req_vld = 1'b0; ld0_req_addr = '0; ld0_req_len = '0; ld0_req_size = '0;
        ld0_req_str = '0; ld0_req_num = '0; ld0_rrdy = 1'b0;
        ld1_req_vld = 1'b0; ld1_req_addr = '0; ld1_req_len = '0; ld1_req_size = '0;
        ld1_req_str = '0; ld1_req_num = '0; ld1_rrdy = 1'b0;
        axi_lsu_arrdy = 1'b0; axi_lsu_rid = '0; axi_lsu_rdata = '0; axi_lsu_rresp = '0;
        axi_lsu_rlast = 1'b0; axi_lsu_rvld = 1'b1;

        // Reset state
        repeat (2) cyc();
        #4;
        chk("rst_arvld", lsu_axi_arvld, 0);
        chk("rst_rrdy", lsu_axi_rrdy, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_err", arb_err, 0);
        chk("rst_ld0_rvld", ld0_rvld, 0);
        chk("rst_ld1_rvld", ld1_rvld, 0);
        chk("rst_araddr", lsu_axi_araddr, 0);
        chk("rst_arid", lsu_axi_arid, 0);

        // Single ld0 burst, len=3
        cyc();
        rst_n = 1'b1; axi_lsu_rvld = 1'b0;
        ld0_req_vld = 1'b1; ld0_req_addr = 10'h040; ld0_req_len = 8'd3;
        ld0_req_size = 3'd3; ld0_req_str = 3'd1; ld0_req_num = 8'd4;
        #4;
        chk("s_rdy0", ld0_req_rdy, 1);
        chk("s_rdy1", ld1_req_rdy, 0);
        chk("s_arvld_idle", lsu_axi_arvld, 0);
        cyc();
        ld0_req_vld = 1'b0; axi_lsu_arrdy = 1'b1;
        #4;
        chk("s_arvld", lsu_axi_arvld, 1);
        chk("s_arid", lsu_axi_arid, 8'h01);
        chk("s_araddr", lsu_axi_araddr, 10'h040);
        chk("s_arlen", lsu_axi_arlen, 3);
        chk("s_arburst", lsu_axi_arburst, 2'b01);
        chk("s_busy", arb_busy, 1);
        chk("s_rdy0_ar", ld0_req_rdy, 0);
        chk("s_rrdy_ar", lsu_axi_rrdy, 0);
        cyc();
        axi_lsu_arrdy = 1'b0; ld0_rrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h01; axi_lsu_rresp = 2'b00;
            axi_lsu_rdata = 64'h100 + 64'(i); axi_lsu_rlast = (i == 3);
            #4;
            chk("s_ld0_rvld", ld0_rvld, 1);
            chk("s_ld0_rdata", ld0_rdata, 64'h100 + 64'(i));
            chk("s_ld0_rlast", ld0_rlast, (i == 3));
            chk("s_ld1_rvld", ld1_rvld, 0);
            chk("s_rrdy", lsu_axi_rrdy, 1);
            cyc();
        end
        axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0;
        #4;
        chk("s_busy_end", arb_busy, 0);
        chk("s_err_end", arb_err, 0);

        // Round-robin with both requesters held valid from reset
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        ld0_req_vld = 1'b1; ld0_req_addr = 10'h011; ld0_req_len = 8'd0;
        ld1_req_vld = 1'b1; ld1_req_addr = 10'h222; ld1_req_len = 8'd0;
        ld0_rrdy = 1'b1; ld1_rrdy = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #4;
            chk("rr_rdy0", ld0_req_rdy, (g % 2 == 0));
            chk("rr_rdy1", ld1_req_rdy, (g % 2 == 1));
            chk("rr_arvld_idle", lsu_axi_arvld, 0);
            cyc();
            axi_lsu_arrdy = 1'b1;
            #4;
            chk("rr_arvld", lsu_axi_arvld, 1);
            chk("rr_arid", lsu_axi_arid, (g % 2 == 1) ? 8'h02 : 8'h01);
            chk("rr_araddr", lsu_axi_araddr, (g % 2 == 1) ? 10'h222 : 10'h011);
            chk("rr_rdy0_ar", ld0_req_rdy, 0);
            cyc();
            axi_lsu_arrdy = 1'b0; axi_lsu_rvld = 1'b1; axi_lsu_rlast = 1'b1;
            axi_lsu_rid = (g % 2 == 1) ? 8'h02 : 8'h01;
            #4;
            chk("rr_ld0_rvld", ld0_rvld, (g % 2 == 0));
            chk("rr_ld1_rvld", ld1_rvld, (g % 2 == 1));
            cyc();
            axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0;
        end
        ld0_req_vld = 1'b0; ld1_req_vld = 1'b0;
        ld0_rrdy = 1'b0; ld1_rrdy = 1'b0;
        #4;
        chk("rr_err", arb_err, 0);

        // AR stall: arrdy low for 5 cycles
        cyc();
        ld1_req_vld = 1'b1; ld1_req_addr = 10'h3ff; ld1_req_len = 8'd7;
        ld1_req_size = 3'd2; ld1_req_str = 3'd5; ld1_req_num = 8'd9;
        #4;
        chk("st_rdy1", ld1_req_rdy, 1);
        cyc();
        ld1_req_vld = 1'b0; ld1_req_addr = 10'h000; ld1_req_len = 8'd0;
        ld1_req_size = 3'd0; ld1_req_str = 3'd0; ld1_req_num = 8'd0;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("st_arvld", lsu_axi_arvld, 1);
            chk("st_araddr", lsu_axi_araddr, 10'h3ff);
            chk("st_arlen", lsu_axi_arlen, 7);
            chk("st_arsize", lsu_axi_arsize, 2);
            chk("st_arstr", lsu_axi_arstr, 5);
            chk("st_arnum", lsu_axi_arnum, 9);
            chk("st_arid", lsu_axi_arid, 8'h02);
            cyc();
        end
        axi_lsu_arrdy = 1'b1;
        #4;
        chk("st_arvld_hs", lsu_axi_arvld, 1);
        cyc();
        axi_lsu_arrdy = 1'b0; ld1_rrdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h02; axi_lsu_rlast = (i == 7);
            axi_lsu_rdata = 64'hABC0 + 64'(i);
            #4;
            if (i == 0) chk("st_arvld_r", lsu_axi_arvld, 0);
            chk("st_ld1_rvld", ld1_rvld, 1);
            chk("st_ld1_rdata", ld1_rdata, 64'hABC0 + 64'(i));
            cyc();
        end
        axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0; ld1_rrdy = 1'b0;
        #4;
        chk("st_busy_end", arb_busy, 0);
        chk("st_err_end", arb_err, 0);

        // ld1 len=1 with ld1_rrdy toggling 1,0,1
        cyc();
        ld1_req_vld = 1'b1; ld1_req_len = 8'd1;
        #4;
        chk("bp_rdy1", ld1_req_rdy, 1);
        cyc();
        ld1_req_vld = 1'b0; axi_lsu_arrdy = 1'b1;
        cyc();
        axi_lsu_arrdy = 1'b0; axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h02;
        axi_lsu_rdata = 64'hAAAA; axi_lsu_rlast = 1'b0; ld1_rrdy = 1'b1;
        #4;
        chk("bp_rrdy_a", lsu_axi_rrdy, 1);
        chk("bp_ld1_rvld_a", ld1_rvld, 1);
        chk("bp_ld0_rvld_a", ld0_rvld, 0);
        if (ld1_rvld && ld1_rrdy) nbeats++;
        cyc();
        ld1_rrdy = 1'b0; axi_lsu_rdata = 64'hBBBB; axi_lsu_rlast = 1'b1;
        #4;
        chk("bp_rrdy_b", lsu_axi_rrdy, 0);
        chk("bp_ld0_rvld_b", ld0_rvld, 0);
        chk("bp_busy_b", arb_busy, 1);
        if (ld1_rvld && ld1_rrdy) nbeats++;
        cyc();
        ld1_rrdy = 1'b1;
        #4;
        chk("bp_rrdy_c", lsu_axi_rrdy, 1);
        chk("bp_ld1_rlast_c", ld1_rlast, 1);
        chk("bp_ld1_rdata_c", ld1_rdata, 64'hBBBB);
        if (ld1_rvld && ld1_rrdy) nbeats++;
        cyc();
        axi_lsu_rvld = 1'b0; axi_lsu_rlast = 1'b0; ld1_rrdy = 1'b0;
        #4;
        chk("bp_beats", nbeats, 2);
        chk("bp_busy_end", arb_busy, 0);
        chk("bp_err_end", arb_err, 0);

        // Error flags: bad rresp, bad rid, short burst
        cyc();
        ld0_req_vld = 1'b1; ld0_req_len = 8'd3;
        cyc();
        ld0_req_vld = 1'b0; axi_lsu_arrdy = 1'b1;
        cyc();
        axi_lsu_arrdy = 1'b0; ld0_rrdy = 1'b1;
        axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h01; axi_lsu_rresp = 2'b00; axi_lsu_rlast = 1'b0;
        #4;
        chk("er_err_pre", arb_err, 0);
        cyc();
        axi_lsu_rresp = 2'b10; axi_lsu_rid = 8'h05; axi_lsu_rlast = 1'b1;
        cyc();
        axi_lsu_rvld = 1'b0; axi_lsu_rresp = 2'b00; axi_lsu_rid = 8'h00; axi_lsu_rlast = 1'b0;
        #4;
        chk("er_err_all", arb_err, 3'b111);
        chk("er_busy", arb_busy, 0);
        cyc();
        err_clr = 1'b1;
        #4;
        chk("er_err_hold", arb_err, 3'b111);
        cyc();
        err_clr = 1'b0;
        #4;
        chk("er_err_clr", arb_err, 3'b000);
        cyc();
        ld0_req_vld = 1'b1; ld0_req_len = 8'd0;
        cyc();
        ld0_req_vld = 1'b0; axi_lsu_arrdy = 1'b1;
        cyc();
        axi_lsu_arrdy = 1'b0;
        axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h01; axi_lsu_rresp = 2'b11; axi_lsu_rlast = 1'b1;
        err_clr = 1'b1;
        cyc();
        axi_lsu_rvld = 1'b0; axi_lsu_rresp = 2'b00; axi_lsu_rlast = 1'b0; err_clr = 1'b0;
        #4;
        chk("er_set_wins", arb_err, 3'b001);
        cyc();
        #4;
        chk("er_sticky", arb_err, 3'b001);

        // Reset in the middle of a burst
        cyc();
        ld0_req_vld = 1'b1; ld0_req_len = 8'd3;
        cyc();
        ld0_req_vld = 1'b0; axi_lsu_arrdy = 1'b1;
        cyc();
        axi_lsu_arrdy = 1'b0; axi_lsu_rvld = 1'b1; axi_lsu_rid = 8'h01; axi_lsu_rlast = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #4;
        chk("mr_ld0_rvld_pre", ld0_rvld, 1);
        cyc();
        rst_n = 1'b1;
        ld1_req_vld = 1'b1; ld1_req_addr = 10'h155; ld1_req_len = 8'd0;
        #4;
        chk("mr_arvld", lsu_axi_arvld, 0);
        chk("mr_rrdy", lsu_axi_rrdy, 0);
        chk("mr_busy", arb_busy, 0);
        chk("mr_err", arb_err, 0);
        chk("mr_ld0_rvld", ld0_rvld, 0);
        chk("mr_rdy1", ld1_req_rdy, 1);
        chk("mr_rdy0", ld0_req_rdy, 0);
        cyc();
        ld1_req_vld = 1'b0; axi_lsu_rvld = 1'b0;
        #4;
        chk("mr_arvld_new", lsu_axi_arvld, 1);
        chk("mr_arid_new", lsu_axi_arid, 8'h02);
        chk("mr_araddr_new", lsu_axi_araddr, 10'h155);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_rd_arb.md
LSU_RD_ARB -- requirements
Module: lsu_rd_arb

Interface
REQ-001 Parameter IRAM_ID, default 8'h01, SHALL be the arid driven for requester 0 (IRAM load).
REQ-002 Parameter WRAM_ID, default 8'h02, SHALL be the arid driven for requester 1 (WRAM load).
REQ-003 clk  in  1  SHALL be the single clock.
REQ-004 rst_n  in  1  SHALL be the reset, synchronous and active-low.
REQ-005 ldN_req_vld  in  1  (N=0,1) SHALL be the burst request valid.
REQ-006 ldN_req_addr  in  10 / ldN_req_len  in  8 / ldN_req_size  in  3 / ldN_req_str  in  3 / ldN_req_num  in  8  SHALL be the burst payload.
REQ-007 ldN_req_rdy  out  1  SHALL be request accept.
REQ-008 ldN_rvld  out  1 / ldN_rdata  out  64 / ldN_rlast  out  1  SHALL be read data routed to requester N.
REQ-009 ldN_rrdy  in  1  SHALL be requester N data ready.
REQ-010 lsu_axi_arid 8 / araddr 10 / arlen 8 / arsize 3 / arburst 2 / arstr 3 / arnum 8 / arvld 1  out  SHALL be the AXI read address channel.
REQ-011 axi_lsu_arrdy  in  1  SHALL be AR ready.
REQ-012 axi_lsu_rid 8 / rdata 64 / rresp 2 / rlast 1 / rvld 1  in  SHALL be the AXI read data channel.
REQ-013 lsu_axi_rrdy  out  1  SHALL be R ready.
REQ-014 arb_busy  out  1  SHALL be high whenever state is not IDLE.
REQ-015 arb_err  out  3  SHALL be sticky error flags: [0] rresp!=0, [1] rid mismatch, [2] burst length mismatch.
REQ-016 err_clr  in  1  SHALL clear arb_err.

Function
REQ-017 FSM SHALL have states IDLE, AR, R; exactly one burst outstanding at any time.
REQ-018 IDLE: winner's ldN_req_rdy SHALL be 1 (combinational on vld and priority); loser's rdy 0; in AR/R both rdy 0.
REQ-019 Arbitration SHALL be round-robin: single requester wins; when both request, winner is the one not granted last; after reset ld0 has priority.
REQ-020 On ldN_req_vld&rdy in cycle T, payload and owner SHALL be registered and lsu_axi_arvld SHALL be 1 from T+1 (state AR).
REQ-021 AR: arvld and all AR fields SHALL be held stable until arvld&arrdy; next state R.
REQ-022 arid SHALL be IRAM_ID/WRAM_ID per owner; arburst SHALL be fixed 2'b01 (INCR).
REQ-023 R: lsu_axi_rrdy SHALL equal owner's ldN_rrdy; owner's ldN_rvld/rdata/rlast SHALL follow axi_lsu_rvld/rdata/rlast combinationally; non-owner rvld 0.
REQ-024 In IDLE and AR, lsu_axi_rrdy SHALL be 0 and both ldN_rvld 0.
REQ-025 An 8-bit beat counter SHALL clear on entering R and increment on each accepted beat (rvld&rrdy).
REQ-026 Accepted beat with rlast SHALL return FSM to IDLE next cycle; new request may be granted in that IDLE cycle.
REQ-027 arb_err[0] SHALL set on an accepted beat with rresp!=2'b00.
REQ-028 arb_err[1] SHALL set on an accepted beat with rid != owner's ID.
REQ-029 arb_err[2] SHALL set when rlast beat's counter value != registered arlen (beats = arlen+1).
REQ-030 Errors SHALL NOT stall the FSM; beats are still forwarded.
REQ-031 err_clr SHALL clear arb_err next cycle; an error set in the same cycle as err_clr SHALL win (flag remains 1).

Reset
REQ-032 On rst_n=0 at a clk edge: state IDLE, arvld 0, rrdy 0, all ldN_rvld 0, arb_busy 0, arb_err 0, counter 0, AR payload registers 0, priority to ld0.
REQ-033 Reset mid-burst SHALL abandon the burst with no further beats forwarded; nothing remembered after release.

Verification
REQ-034 ld0 only, addr=10'h040, len=3; arrdy immediate; 4 beats rlast on 4th -> arid=8'h01, arburst=2'b01, 4 beats on ld0, arb_err=0, arb_busy low after last beat.
REQ-035 ld0 and ld1 both held valid from reset -> grants ld0, ld1, ld0, ld1 in order; each AR issued T+1 after its handshake.
REQ-036 arrdy held 0 for 5 cycles -> arvld and all AR fields stable for 5 cycles; transfer to R only on arrdy=1.
REQ-037 ld1 burst len=1 with ld1_rrdy toggling 1,0,1 -> lsu_axi_rrdy mirrors it; exactly 2 beats reach ld1; ld0_rvld stays 0.
REQ-038 Beat with rresp=2'b10, rid=8'h05, rlast on 2nd beat of len=3 -> arb_err=3'b111; err_clr pulse -> 3'b000; err_clr coincident with new rresp error -> arb_err[0]=1.
REQ-039 rst_n low during R after 2 beats -> next cycle arvld=0, rrdy=0, arb_busy=0, arb_err=0; a following ld1 request is granted normally.
